alu_cmd_driver: RTL and testbench

- Automatic initiator for the `top_alu_interface` button/switch protocol.
- Accepts an operand pair and an opcode as one parallel command, then generates the switch values and `btn_set`/`btn_select` pulses that load operand A, operand B and the operator.
- Waits for the ALU result, samples the `leds` bus, and returns the result with a done strobe.
- Replaces manual board stimulus in system tests; a later UART front-end will drive it.

---
 rtl/alu_cmd_driver.sv | 187 ++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command driver for the top_alu_interface button/switch protocol: loads operand A, operand B
// and the opcode through timed btn_set/btn_select pulses, then samples the ALU result.
module alu_cmd_driver #(
    parameter int NB_OP      = 6,
    parameter int NB_DATA    = 8,
    parameter int PULSE_LEN  = 2,
    parameter int GAP_LEN    = 2,
    parameter int SETTLE_LEN = 4
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_op_a,
    input  logic [NB_DATA-1:0] i_op_b,
    input  logic [NB_OP-1:0]   i_opcode,
    input  logic [NB_DATA-1:0] i_leds,
    output logic [NB_DATA-1:0] o_switches,
    output logic               o_btn_set,
    output logic               o_btn_select,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_done,
    output logic               o_busy
);

    localparam int CNT_MAX0 = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_MAX  = (CNT_MAX0 > SETTLE_LEN) ? CNT_MAX0 : SETTLE_LEN;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_CNT  = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_CNT    = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_SETUP, ST_SET_PULSE, ST_SET_GAP,
        ST_SEL_PULSE, ST_SEL_GAP, ST_SETTLE, ST_CAPTURE, ST_DONE
    } state_t;

    typedef enum logic [1:0] {PH_A, PH_B, PH_OP} phase_t;

    state_t             state_r, state_s;
    phase_t             phase_r, phase_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [NB_DATA-1:0] op_a_r, op_b_r;
    logic [NB_OP-1:0]   opcode_r;
    logic [NB_DATA-1:0] switches_r, switches_s, phase_value_s;
    logic               btn_set_r, btn_set_s;
    logic               btn_select_r, btn_select_s;
    logic [NB_DATA-1:0] result_r;
    logic               done_r, done_s;
    logic               busy_r, busy_s;

    // Next-state sequencing; each timed state holds for its programmed length via cnt.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: state_s = ST_SETUP;
            ST_SETUP: begin
                state_s = ST_SET_PULSE;
                cnt_s   = PULSE_CNT;
            end
            ST_SET_PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_SET_GAP;
                    cnt_s   = GAP_CNT;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SET_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_SEL_PULSE;
                    cnt_s   = PULSE_CNT;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SEL_PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_SEL_GAP;
                    cnt_s   = GAP_CNT;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SEL_GAP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (phase_r == PH_OP) begin
                    // The OP select pulse has already wrapped the interface back to operand A.
                    state_s = ST_SETTLE;
                    cnt_s   = SETTLE_CNT;
                    phase_s = PH_A;
                end else begin
                    state_s = ST_SETUP;
                    phase_s = (phase_r == PH_A) ? PH_B : PH_OP;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_CAPTURE: state_s = ST_DONE;
            ST_DONE:    state_s = ST_IDLE;
            default: begin
                state_s = ST_IDLE;
                phase_s = PH_A;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the upcoming state, so the registered outputs line up with it.
    always_comb begin
        case (phase_s)
            PH_A:    phase_value_s = op_a_r;
            PH_B:    phase_value_s = op_b_r;
            PH_OP:   phase_value_s = NB_DATA'(opcode_r);
            default: phase_value_s = op_a_r;
        endcase
        if (state_s == ST_SETUP) begin
            switches_s = phase_value_s;
        end else begin
            switches_s = switches_r;
        end
        btn_set_s    = (state_s == ST_SET_PULSE);
        btn_select_s = (state_s == ST_SEL_PULSE);
        busy_s       = (state_s != ST_IDLE) && (state_s != ST_LOAD) && (state_s != ST_DONE);
        done_s       = (state_s == ST_DONE);
    end

    // State, command latch and registered outputs.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            phase_r      <= PH_A;
            cnt_r        <= CNT_ZERO;
            op_a_r       <= {NB_DATA{1'b0}};
            op_b_r       <= {NB_DATA{1'b0}};
            opcode_r     <= {NB_OP{1'b0}};
            switches_r   <= {NB_DATA{1'b0}};
            btn_set_r    <= 1'b0;
            btn_select_r <= 1'b0;
            result_r     <= {NB_DATA{1'b0}};
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            phase_r      <= phase_s;
            cnt_r        <= cnt_s;
            switches_r   <= switches_s;
            btn_set_r    <= btn_set_s;
            btn_select_r <= btn_select_s;
            done_r       <= done_s;
            busy_r       <= busy_s;
            if (state_r == ST_IDLE && i_start) begin
                op_a_r   <= i_op_a;
                op_b_r   <= i_op_b;
                opcode_r <= i_opcode;
            end
            if (state_r == ST_CAPTURE) begin
                result_r <= i_leds;
            end
        end
    end

    assign o_switches   = switches_r;
    assign o_btn_set    = btn_set_r;
    assign o_btn_select = btn_select_r;
    assign o_result     = result_r;
    assign o_done       = done_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two driver instances (default and short timing) each talk to a small
// behavioural model of top_alu_interface; a scoreboard checks every done strobe.
module tb_alu_cmd_driver;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_ext;
        logic [7:0] res;
        int         start_edge;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    logic [7:0] drv_a [2];
    logic [7:0] drv_b [2];
    logic [5:0] drv_op [2];
    logic       drv_start [2];
    logic [7:0] leds [2];
    logic [7:0] sw [2];
    logic       bs [2];
    logic       bl [2];
    logic [7:0] res [2];
    logic       done [2];
    logic       busy [2];

    exp_t q0 [$];
    exp_t q1 [$];
    int   done_cnt [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_driver dut0 (
        .clk(clk), .i_reset(rst), .i_start(drv_start[0]), .i_op_a(drv_a[0]), .i_op_b(drv_b[0]),
        .i_opcode(drv_op[0]), .i_leds(leds[0]), .o_switches(sw[0]), .o_btn_set(bs[0]),
        .o_btn_select(bl[0]), .o_result(res[0]), .o_done(done[0]), .o_busy(busy[0])
    );

    alu_cmd_driver #(.PULSE_LEN(1), .GAP_LEN(3), .SETTLE_LEN(1)) dut1 (
        .clk(clk), .i_reset(rst), .i_start(drv_start[1]), .i_op_a(drv_a[1]), .i_op_b(drv_b[1]),
        .i_opcode(drv_op[1]), .i_leds(leds[1]), .o_switches(sw[1]), .o_btn_set(bs[1]),
        .o_btn_select(bl[1]), .o_result(res[1]), .o_done(done[1]), .o_busy(busy[1])
    );

    // Behavioural top_alu_interface: rising btn_set loads the selected register,
    // rising btn_select advances A -> B -> OP -> A.
    logic [1:0] m_sel [2];
    logic [7:0] m_a [2];
    logic [7:0] m_b [2];
    logic [5:0] m_op [2];
    logic       m_bs [2];
    logic       m_bl [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_sel[k] <= 2'd0; m_a[k] <= 8'h00; m_b[k] <= 8'h00; m_op[k] <= 6'h00;
                m_bs[k] <= 1'b0; m_bl[k] <= 1'b0;
            end else begin
                if (bs[k] && !m_bs[k]) begin
                    if (m_sel[k] == 2'd0) m_a[k] <= sw[k];
                    else if (m_sel[k] == 2'd1) m_b[k] <= sw[k];
                    else m_op[k] <= sw[k][5:0];
                end
                if (bl[k] && !m_bl[k]) m_sel[k] <= (m_sel[k] == 2'd2) ? 2'd0 : m_sel[k] + 2'd1;
                m_bs[k] <= bs[k];
                m_bl[k] <= bl[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            leds[k] = 8'h00;
            case (m_op[k])
                OP_ADD:  leds[k] = m_a[k] + m_b[k];
                OP_SUB:  leds[k] = m_a[k] - m_b[k];
                OP_AND:  leds[k] = m_a[k] & m_b[k];
                OP_OR:   leds[k] = m_a[k] | m_b[k];
                OP_XOR:  leds[k] = m_a[k] ^ m_b[k];
                default: leds[k] = 8'h00;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: protocol tracking per channel, scoreboard pop on every done strobe.
    initial begin
        logic       busy_q [2] = '{1'b0, 1'b0};
        logic       bs_q [2] = '{1'b0, 1'b0};
        logic       bl_q [2] = '{1'b0, 1'b0};
        logic       done_q [2] = '{1'b0, 1'b0};
        logic [7:0] sw_q [2] = '{8'h00, 8'h00};
        logic [7:0] hold_sw [2];
        logic       holding [2] = '{1'b0, 1'b0};
        logic [7:0] loaded [2][3];
        int         set_cnt [2] = '{0, 0};
        int         sel_cnt [2] = '{0, 0};
        int         wid_set [2] = '{0, 0};
        int         wid_sel [2] = '{0, 0};
        bit         bad_w [2] = '{1'b0, 1'b0};
        bit         ovl [2] = '{1'b0, 1'b0};
        bit         unstable [2] = '{1'b0, 1'b0};
        exp_t       e;
        int         plen;
        done_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                plen = (k == 0) ? 2 : 1;
                if (busy[k] === 1'b1 && busy_q[k] !== 1'b1) begin
                    set_cnt[k] = 0; sel_cnt[k] = 0; wid_set[k] = 0; wid_sel[k] = 0;
                    bad_w[k] = 1'b0; ovl[k] = 1'b0; unstable[k] = 1'b0; holding[k] = 1'b0;
                end
                if (bs[k] === 1'b1 && bl[k] === 1'b1) ovl[k] = 1'b1;
                if (bs[k] === 1'b1) begin
                    if (bs_q[k] !== 1'b1) begin
                        if (set_cnt[k] < 3) loaded[k][set_cnt[k]] = sw[k];
                        set_cnt[k]++;
                        if (sw[k] !== sw_q[k]) unstable[k] = 1'b1;
                        hold_sw[k] = sw[k];
                        holding[k] = 1'b1;
                    end
                    wid_set[k]++;
                end else if (bs_q[k] === 1'b1) begin
                    if (wid_set[k] != plen) bad_w[k] = 1'b1;
                    wid_set[k] = 0;
                end
                if (bl[k] === 1'b1) begin
                    if (bl_q[k] !== 1'b1) begin
                        sel_cnt[k]++;
                        holding[k] = 1'b0;
                    end
                    wid_sel[k]++;
                end else if (bl_q[k] === 1'b1) begin
                    if (wid_sel[k] != plen) bad_w[k] = 1'b1;
                    wid_sel[k] = 0;
                end
                if (holding[k] && sw[k] !== hold_sw[k]) unstable[k] = 1'b1;
                if (done[k] === 1'b1) begin
                    done_cnt[k]++;
                    chk($sformatf("ch%0d_done_single_cycle", k), {31'd0, done_q[k]}, 32'd0);
                    chk($sformatf("ch%0d_busy_low_at_done", k), {31'd0, busy[k]}, 32'd0);
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        chk($sformatf("ch%0d_unexpected_done", k), 32'd1, 32'd0);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk($sformatf("ch%0d_result", k), {24'd0, res[k]}, {24'd0, e.res});
                        chk($sformatf("ch%0d_latency", k), cyc - e.start_edge, e.lat);
                        chk($sformatf("ch%0d_set_pulses", k), set_cnt[k], 32'd3);
                        chk($sformatf("ch%0d_sel_pulses", k), sel_cnt[k], 32'd3);
                        chk($sformatf("ch%0d_pulse_width_ok", k), {31'd0, bad_w[k]}, 32'd0);
                        chk($sformatf("ch%0d_no_overlap", k), {31'd0, ovl[k]}, 32'd0);
                        chk($sformatf("ch%0d_switch_stable", k), {31'd0, unstable[k]}, 32'd0);
                        chk($sformatf("ch%0d_sw_a", k), {24'd0, loaded[k][0]}, {24'd0, e.a});
                        chk($sformatf("ch%0d_sw_b", k), {24'd0, loaded[k][1]}, {24'd0, e.b});
                        chk($sformatf("ch%0d_sw_op", k), {24'd0, loaded[k][2]}, {24'd0, e.op_ext});
                    end
                end
                busy_q[k] = busy[k]; bs_q[k] = bs[k]; bl_q[k] = bl[k];
                done_q[k] = done[k]; sw_q[k] = sw[k];
            end
        end
    end

    task automatic issue(input int k, input logic [7:0] a_v, input logic [7:0] b_v,
                         input logic [5:0] op_v, input logic [7:0] res_v, input int lat_v,
                         input bit push, input bit hold, output int se);
        exp_t e;
        @(negedge clk);
        drv_a[k] = a_v; drv_b[k] = b_v; drv_op[k] = op_v; drv_start[k] = 1'b1;
        se = cyc + 1;
        e.a = a_v; e.b = b_v; e.op_ext = {2'b00, op_v}; e.res = res_v;
        e.start_edge = se; e.lat = lat_v;
        if (push) begin
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (!hold) begin
            @(negedge clk);
            drv_start[k] = 1'b0;
        end
    endtask

    task automatic wait_done(input int k, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done[k] === 1'b1) seen = 1'b1;
        end
        chk($sformatf("ch%0d_done_seen", k), {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 100 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk($sformatf("%s_ch%0d_switches", tag, k), {24'd0, sw[k]}, 32'd0);
        chk($sformatf("%s_ch%0d_btns", tag, k), {30'd0, bs[k], bl[k]}, 32'd0);
        chk($sformatf("%s_ch%0d_result", tag, k), {24'd0, res[k]}, 32'd0);
        chk($sformatf("%s_ch%0d_done_busy", tag, k), {30'd0, done[k], busy[k]}, 32'd0);
    endtask

    initial begin
        int  se;
        int  rises;
        bit  prev;
        for (int k = 0; k < 2; k++) begin
            drv_a[k] = 8'h00; drv_b[k] = 8'h00; drv_op[k] = 6'h00; drv_start[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        rst = 1'b0;

        // ADD then SUB back-to-back at the earliest IDLE cycle.
        issue(0, 8'h0A, 8'h05, OP_ADD, 8'h0F, 33, 1'b1, 1'b0, se);
        wait_done(0, 60);
        issue(0, 8'h0A, 8'h05, OP_SUB, 8'h05, 33, 1'b1, 1'b0, se);
        wait_done(0, 60);
        issue(0, 8'hA0, 8'h05, OP_OR, 8'hA5, 33, 1'b1, 1'b0, se);
        wait_done(0, 60);

        // Start held through the whole command and the DONE cycle: one command only.
        issue(0, 8'hFF, 8'h01, OP_ADD, 8'h00, 33, 1'b1, 1'b1, se);
        wait_done(0, 60);
        @(negedge clk);
        drv_start[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_no_second_cmd", {31'd0, busy[0]}, 32'd0);

        // Start pulses mid-command with different operands must be ignored.
        issue(0, 8'h03, 8'h05, OP_SUB, 8'hFE, 33, 1'b1, 1'b0, se);
        drv_a[0] = 8'h77; drv_b[0] = 8'h11; drv_op[0] = OP_XOR;
        wait_until(se + 4);
        drv_start[0] = 1'b1;
        @(negedge clk);
        drv_start[0] = 1'b0;
        wait_until(se + 19);
        drv_start[0] = 1'b1;
        @(negedge clk);
        drv_start[0] = 1'b0;
        wait_done(0, 60);
        repeat (3) @(negedge clk);

        // Reset during operand B's set pulse aborts the command.
        issue(0, 8'h11, 8'h22, OP_ADD, 8'h33, 33, 1'b0, 1'b0, se);
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 40 && rises < 2; i++) begin
            @(negedge clk);
            if (bs[0] === 1'b1 && !prev) rises++;
            prev = bs[0];
        end
        chk("abort_reached_b_set", rises, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk_zero(0, "abort");
        rst = 1'b0;
        issue(0, 8'h03, 8'h04, OP_ADD, 8'h07, 33, 1'b1, 1'b0, se);
        wait_done(0, 60);

        // Short-timing instance.
        issue(1, 8'h12, 8'h34, OP_ADD, 8'h46, 30, 1'b1, 1'b0, se);
        wait_done(1, 60);

        repeat (4) @(negedge clk);
        chk("ch0_queue_empty", q0.size(), 32'd0);
        chk("ch1_queue_empty", q1.size(), 32'd0);
        chk("ch0_done_count", done_cnt[0], 32'd6);
        chk("ch1_done_count", done_cnt[1], 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
